// File: rtl/d_cmp_pkg.sv
// Shared codes for the sequential decode-stage operand comparator.
package d_cmp_pkg;

  // Compare mode: operand pairing and signedness.
  typedef enum logic [1:0] {
    MODE_UNS    = 2'b00,  // unsigned A:B
    MODE_SGN    = 2'b01,  // signed A:B
    MODE_SGN_Z  = 2'b10,  // signed A:0
    MODE_UNS_Z  = 2'b11   // unsigned A:0
  } mode_e;

  // Branch condition evaluated against the compare result.
  typedef enum logic [2:0] {
    COND_EQ  = 3'b000,
    COND_NE  = 3'b001,
    COND_LEZ = 3'b010,
    COND_GTZ = 3'b011,
    COND_LTZ = 3'b100,
    COND_GEZ = 3'b101,
    COND_NV0 = 3'b110,
    COND_NV1 = 3'b111
  } cond_e;

  // Three-way compare codes; 2'b11 is never produced.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Branch-taken decision for a condition code and a compare result.
  function automatic logic branch_taken(input logic [2:0] cond, input logic [1:0] res);
    logic tk;
    tk = 1'b0;
    case (cond)
      COND_EQ:  tk = (res == CMP_EQ);
      COND_NE:  tk = (res != CMP_EQ);
      COND_LEZ: tk = (res != CMP_GT);
      COND_GTZ: tk = (res == CMP_GT);
      COND_LTZ: tk = (res == CMP_LT);
      COND_GEZ: tk = (res != CMP_LT);
      default:  tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/d_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module d_cmp_chunk
  import d_cmp_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  // Equality and unsigned greater-than of the two slices.
  always_comb begin
    eq_o = (a_i == b_i);
    gt_o = (a_i > b_i);
  end

endmodule

// File: rtl/d_cmp_seq.sv
// Multi-cycle operand comparator: walks the operands MSB chunk first,
// stops at the first differing chunk, and registers the compare code
// together with the branch-taken flag for the latched condition.
module d_cmp_seq
  import d_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic [2:0]       cond,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic             taken
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
    $error("d_cmp_seq: CHUNK must be positive and divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2:0]         cond_q, cond_d;
  logic [1:0]         result_q, result_d;
  logic               taken_q, taken_d;

  logic [CHUNK-1:0]   ch_a, ch_b;
  logic               ch_eq, ch_gt;

  // Select the chunk currently under examination.
  always_comb begin
    ch_a = opa_q[int'(idx_q)*CHUNK +: CHUNK];
    ch_b = opb_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  d_cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i  (ch_a),
    .b_i  (ch_b),
    .eq_o (ch_eq),
    .gt_o (ch_gt)
  );

  // Next-state logic: accept, chunk walk with early exit, result capture.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cond_d   = cond_q;
    result_d = result_q;
    taken_d  = taken_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d = a;
          opb_d = mode[1] ? '0 : b;
          // Flipping the sign bit of both operands maps two's complement
          // order onto unsigned order, so the chunk walk stays unsigned.
          if ((mode == MODE_SGN) || (mode == MODE_SGN_Z)) begin
            opa_d[WIDTH-1] = ~opa_d[WIDTH-1];
            opb_d[WIDTH-1] = ~opb_d[WIDTH-1];
          end
          cond_d  = cond;
          idx_d   = IDX_W'(STEPS - 1);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!ch_eq) begin
          result_d = ch_gt ? CMP_GT : CMP_LT;
          taken_d  = branch_taken(cond_q, result_d);
          state_d  = ST_DONE;
        end else if (idx_q == '0) begin
          result_d = CMP_EQ;
          taken_d  = branch_taken(cond_q, CMP_EQ);
          state_d  = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cond_q   <= '0;
      result_q <= CMP_EQ;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cond_q   <= cond_d;
      result_q <= result_d;
      taken_q  <= taken_d;
    end
  end

  // Handshake and result outputs decoded from registered state.
  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
    result = result_q;
    taken  = taken_q;
  end

endmodule

// File: tb/tb_d_cmp_seq.sv
// Self-checking bench for d_cmp_seq (WIDTH=32, CHUNK=8).
module tb_d_cmp_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int STEPS = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       mode = '0;
  logic [2:0]       cond = '0;
  logic             busy, done, taken;
  logic [1:0]       result;

  d_cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .cond   (cond),
    .busy   (busy),
    .done   (done),
    .result (result),
    .taken  (taken)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic [2:0]  cond;
    logic [1:0]  res;
    logic        tk;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [1:0] res;
    logic       tk;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Reference: direct signed/unsigned compare, latency from first differing chunk.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mm,
                       input logic [2:0] mc, output logic [1:0] res, output logic tk,
                       output int cyc);
    logic [31:0] bb;
    logic [31:0] x;
    int k;
    bb = mm[1] ? 32'h0 : mb;
    if (mm == 2'b01 || mm == 2'b10)
      res = ($signed(ma) > $signed(bb)) ? 2'b01 : (($signed(ma) < $signed(bb)) ? 2'b10 : 2'b00);
    else
      res = (ma > bb) ? 2'b01 : ((ma < bb) ? 2'b10 : 2'b00);
    x = ma ^ bb;
    k = STEPS;
    for (int i = STEPS - 1; i >= 0; i--) begin
      if (((x >> (i * CHUNK)) & 32'hFF) != 0) begin
        k = STEPS - i;
        break;
      end
    end
    cyc = k + 1;
    case (mc)
      3'b000: tk = (res == 2'b00);
      3'b001: tk = (res != 2'b00);
      3'b010: tk = (res != 2'b01);
      3'b011: tk = (res == 2'b01);
      3'b100: tk = (res == 2'b10);
      3'b101: tk = (res != 2'b10);
      default: tk = 1'b0;
    endcase
  endtask

  // Present a request at the current time and let the accept edge pass.
  task automatic drive_start(input logic [31:0] ta, input logic [31:0] tb2, input logic [1:0] tm,
                             input logic [2:0] tc, input logic [1:0] er, input logic et,
                             input int ecyc, input string nm);
    exp_t e;
    e.res = er; e.tk = et; e.cyc = ecyc;
    exp_q.push_back(e);
    a = ta; b = tb2; mode = tm; cond = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; mode = 2'($urandom); cond = 3'($urandom);
    acc_edge = edge_cnt;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    exp_t e;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = exp_q.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end else begin
      chk({nm, "_result"}, 32'(result), 32'(e.res));
      chk({nm, "_taken"}, 32'(taken), 32'(e.tk));
      chk({nm, "_cycle"}, 32'(edge_cnt - acc_edge + 1), 32'(e.cyc));
    end
  endtask

  task automatic run_cmp(input logic [31:0] ta, input logic [31:0] tb2, input logic [1:0] tm,
                         input logic [2:0] tc, input logic [1:0] er, input logic et,
                         input int ecyc, input string nm);
    @(negedge clk);
    drive_start(ta, tb2, tm, tc, er, et, ecyc, nm);
    wait_done(nm);
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{32'h80000000, 32'h00000001, 2'b00, 3'b000, 2'b01, 1'b0, 2};
    vt[1]  = '{32'h80000000, 32'h00000001, 2'b01, 3'b100, 2'b10, 1'b1, 2};
    vt[2]  = '{32'h12345678, 32'h12345678, 2'b00, 3'b000, 2'b00, 1'b1, 5};
    vt[3]  = '{32'h12345678, 32'h12345678, 2'b00, 3'b001, 2'b00, 1'b0, 5};
    vt[4]  = '{32'hFFFFFFFF, 32'hDEADBEEF, 2'b10, 3'b010, 2'b10, 1'b1, 2};
    vt[5]  = '{32'h00000000, 32'hDEADBEEF, 2'b10, 3'b011, 2'b00, 1'b0, 5};
    vt[6]  = '{32'h00000100, 32'h000000FF, 2'b00, 3'b101, 2'b01, 1'b1, 4};
    vt[7]  = '{32'h00000005, 32'h00000009, 2'b11, 3'b011, 2'b01, 1'b1, 5};
    vt[8]  = '{32'h00000001, 32'h00000002, 2'b00, 3'b110, 2'b10, 1'b0, 5};
    vt[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 2'b01, 3'b011, 2'b01, 1'b1, 5};
    vt[10] = '{32'h7FFFFFFF, 32'h12345678, 2'b10, 3'b101, 2'b01, 1'b1, 2};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++)
      run_cmp(vt[i].a, vt[i].b, vt[i].mode, vt[i].cond, vt[i].res, vt[i].tk, vt[i].cyc,
              $sformatf("vec%0d", i));

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rm, er;
      logic [2:0]  rc;
      logic        et;
      int          ec;
      ra = $urandom;
      rb = (i % 2 == 1) ? (ra ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
      rm = 2'(i % 4);
      rc = 3'($urandom_range(0, 7));
      model(ra, rb, rm, rc, er, et, ec);
      run_cmp(ra, rb, rm, rc, er, et, ec, $sformatf("rnd%0d", i));
    end

    // Start pulsed while busy is ignored and not queued
    @(negedge clk);
    drive_start(32'hCAFE0000, 32'hCAFE0000, 2'b00, 3'b000, 2'b00, 1'b1, 5, "ign");
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h0; mode = 2'b00; cond = 3'b001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    @(posedge clk); #1;
    chk("ign_no_queue_busy", 32'(busy), 32'd0);
    chk("ign_no_queue_done", 32'(done), 32'd0);

    // Start accepted in the DONE cycle: back-to-back compares
    run_cmp(32'h01000000, 32'h02000000, 2'b00, 3'b100, 2'b10, 1'b1, 2, "b2b_a");
    drive_start(32'h00000100, 32'h000000FF, 2'b00, 3'b011, 2'b01, 1'b1, 4, "b2b_b");
    chk("b2b_b_done_low", 32'(done), 32'd0);
    wait_done("b2b_b");

    // Reset mid-RUN clears outputs asynchronously; no done afterwards
    @(negedge clk);
    drive_start(32'h55555555, 32'h55555555, 2'b00, 3'b000, 2'b00, 1'b1, 5, "abort");
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    void'(exp_q.pop_front());
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_taken", 32'(taken), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
    end
    run_cmp(32'h80000000, 32'h7FFFFFFF, 2'b01, 3'b010, 2'b10, 1'b1, 2, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_cmp_seq.md
# d_cmp_seq

Parametrised, multi-cycle operand comparator for the decode stage. It is the successor to the single-cycle D-stage compare. It compares two WIDTH-bit operands most-significant chunk first, CHUNK bits per cycle, in unsigned, signed or compare-with-zero mode, and exits early on the first differing chunk. It returns the three-way compare code and a registered branch-taken flag for the selected branch condition, with a start/busy/done handshake towards the stall logic.

## Interface
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle; must divide WIDTH. STEPS = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; one clock domain.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored in zero modes.
- mode  input  2  00 unsigned A:B, 01 signed A:B, 10 signed A:0, 11 unsigned A:0.
- cond  input  3  000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ, 110/111 never-taken.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result and taken become valid.
- result  output  2  00 A==B, 01 A>B, 10 A<B; 11 never driven.
- taken  output  1  branch condition evaluated against result.

## Operation
- States: IDLE, RUN, DONE.
- Reset (asynchronous, low): state=IDLE, index=0, busy=0, done=0, result=00, taken=0, and latched operands cleared.
- IDLE or DONE with start=1:
  - Latch opA=a. Latch opB=b, or 0 in modes 1x.
  - Latch cond and mode.
  - index=STEPS-1. Go to RUN.
- Signed modes: invert the MSB of opA and opB at latch time. The rest of the comparison is unsigned.
- RUN, each cycle: compare opA and opB on chunk bits [index*CHUNK+CHUNK-1 : index*CHUNK].
  - Chunks differ: result=01 if opA chunk > opB chunk, else 10. Go to DONE.
  - Chunks equal and index==0: result=00. Go to DONE.
  - Otherwise: index decrements.
- taken is registered in the same edge that enters DONE:
  - EQ: result==00.
  - NE: result!=00.
  - LEZ: result!=01.
  - GTZ: result==01.
  - LTZ: result==10.
  - GEZ: result!=10.
  - 110/111: 0.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- result and taken hold their value until the next transition into DONE. They do not clear on a new start.
- start while busy=1 is ignored and has no queue. The caller must hold start until busy rises.
- Inputs a, b, mode and cond are don't-care outside the start-accept cycle.

## Timing
- Let the accept edge be edge 0, and k be the number of chunks examined (1..STEPS).
- busy is high from edge 0 through edge k.
- done and valid result/taken appear after edge k. Latency is k+1 cycles from start.
- Fastest case: top chunk differs, done in cycle 2.
- Equal operands: done in cycle STEPS+1. This is cycle 5 for 32/8.
- Back-to-back: start accepted during the DONE cycle enters RUN at the next edge. Zero idle cycles.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced for the aborted compare.
- CHUNK==WIDTH degenerates to a 2-cycle compare. This configuration must be legal.

## Structure
- Shared package d_cmp_pkg holds:
  - mode codes;
  - cond codes;
  - result codes CMP_EQ=00, CMP_GT=01, CMP_LT=10;
  - state encoding IDLE/RUN/DONE.
- One sub-module, d_cmp_chunk: a combinational CHUNK-bit unsigned compare that outputs eq and gt. d_cmp_seq instantiates it once, fed by an index-selected slice.
- Elaboration check: WIDTH % CHUNK == 0.

## Test plan
- WIDTH=32, CHUNK=8, mode=00, a=0x80000000, b=0x00000001, cond=EQ -> result=01, taken=0, done in cycle 2.
- Same operands, mode=01, cond=LTZ -> result=10, taken=1, done in cycle 2.
- a=b=0x12345678, mode=00, cond=EQ -> result=00, taken=1, done in cycle 5. Repeat with cond=NE -> taken=0.
- mode=10:
  - a=0xFFFFFFFF, cond=LEZ -> result=10, taken=1, cycle 2.
  - a=0x00000000, cond=GTZ -> result=00, taken=0, cycle 5.
- mode=00, a=0x00000100, b=0x000000FF -> differ at third chunk, result=01, done in cycle 4.
- Control and reset:
  - start pulsed while busy -> ignored, first result unchanged.
  - start during DONE -> second compare starts next edge.
  - reset dropped low mid-RUN -> busy=0, done=0, result=00, taken=0 asynchronously, and no done pulse after release.
